fetch_instruction: RTL and testbench

- Fetch stage that feeds the execute stage. Holds the PC and issues instruction-memory reads over a request/done handshake.
- Presents the fetched instruction plus PC+2 (next_PC_normal) to decode.
- Consumes the execute stage's resolved target (updatedPC) as a redirect and squashes wrong-path fetches.
- Stops issuing fetches after a HALT instruction is accepted.

---
 rtl/fetch_instruction_pkg.sv | 21 ++
 rtl/fetch_pc_reg.sv | 34 +++
 rtl/rca_16b.sv | 21 ++
 rtl/fetch_instruction.sv | 152 +++++++++++++++
 tb/tb_fetch_instruction.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_instruction_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, opcode
// constants and a small decode helper used when an instruction is presented.
package fetch_instruction_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2,
    HALTED  = 2'd3
  } fetch_state_t;

  localparam logic [4:0]  OP_HALT   = 5'b00000;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [15:0] PC_STEP   = 16'h0002;

  // True when the word carries the HALT opcode in its top five bits.
  function automatic logic is_halt(input logic [15:0] word);
    return word[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: loads either the redirect target or PC+2 when
// enabled, and returns to RESET_PC on an asynchronous reset.
module fetch_pc_reg #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic        sel_redirect,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] pc_plus2,
  output logic [15:0] pc
);

  logic [15:0] pc_reg;
  logic [15:0] pc_next;

  // Redirect target takes precedence over sequential advance.
  always_comb begin
    pc_next = sel_redirect ? redirect_pc : pc_plus2;
  end

  // PC state; only changes when the fetch FSM asks for a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (load_en) begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/rca_16b.sv
// 16-bit ripple-carry adder. The carry out of bit 15 is dropped, so the sum
// wraps modulo 2^16.
module rca_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  logic [15:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < 16; gi++) begin : g_fa
    assign sum[gi] = a[gi] ^ b[gi] ^ carry[gi];
    if (gi < 15) begin : g_carry
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  end

endmodule

// File: rtl/fetch_instruction.sv
// Fetch stage: issues instruction-memory reads from the PC, presents the
// returned word with PC+2 to decode, follows execute-stage redirects (squashing
// a read already in flight) and stops after a HALT or an odd redirect target.
module fetch_instruction #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = fetch_instruction_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_PC,
  input  logic        stall,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_stall,
  input  logic        mem_done,
  input  logic [15:0] mem_data_in,
  output logic [15:0] instr,
  output logic [15:0] next_PC_normal,
  output logic        instr_valid,
  output logic        halted,
  output logic        err
);

  import fetch_instruction_pkg::*;

  fetch_state_t state_reg;
  logic         squash_reg;
  logic [15:0]  instr_reg;
  logic [15:0]  next_pc_reg;
  logic         instr_valid_reg;
  logic         halted_reg;
  logic         err_reg;
  logic         mem_rd_reg;

  logic [15:0]  pc;
  logic [15:0]  pc_plus2;
  logic         pc_load_en;
  logic         accept_data;

  // A returning word is kept only when it belongs to the current path.
  always_comb begin
    accept_data = (state_reg == WAIT) && mem_done && !squash_reg;
    pc_load_en  = redirect || accept_data;
  end

  rca_16b u_pc_adder (
    .a   (pc),
    .b   (PC_STEP),
    .cin (1'b0),
    .sum (pc_plus2)
  );

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .load_en      (pc_load_en),
    .sel_redirect (redirect),
    .redirect_pc  (redirect_PC),
    .pc_plus2     (pc_plus2),
    .pc           (pc)
  );

  // Fetch FSM with registered outputs; redirect overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= FETCH;
      squash_reg      <= 1'b0;
      instr_reg       <= NOP_INSTR;
      next_pc_reg     <= 16'h0000;
      instr_valid_reg <= 1'b0;
      halted_reg      <= 1'b0;
      err_reg         <= 1'b0;
      mem_rd_reg      <= 1'b0;
    end else if (redirect) begin
      instr_reg       <= NOP_INSTR;
      instr_valid_reg <= 1'b0;
      if (redirect_PC[0]) begin
        // Odd target cannot be fetched: flag it and stop.
        err_reg    <= 1'b1;
        halted_reg <= 1'b1;
        state_reg  <= HALTED;
        squash_reg <= 1'b0;
        mem_rd_reg <= 1'b0;
      end else if (state_reg == WAIT && !mem_done) begin
        // The outstanding read cannot be cancelled; drop it when it lands.
        squash_reg <= 1'b1;
        halted_reg <= 1'b0;
        mem_rd_reg <= 1'b0;
      end else begin
        squash_reg <= 1'b0;
        halted_reg <= 1'b0;
        state_reg  <= FETCH;
        mem_rd_reg <= 1'b1;
      end
    end else begin
      case (state_reg)
        FETCH: begin
          if (!mem_rd_reg) begin
            // First cycle out of reset: raise the request.
            mem_rd_reg <= 1'b1;
          end else if (!mem_stall) begin
            mem_rd_reg <= 1'b0;
            state_reg  <= WAIT;
          end
        end
        WAIT: begin
          if (mem_done) begin
            if (squash_reg) begin
              squash_reg <= 1'b0;
              mem_rd_reg <= 1'b1;
              state_reg  <= FETCH;
            end else begin
              instr_reg       <= mem_data_in;
              next_pc_reg     <= pc_plus2;
              instr_valid_reg <= 1'b1;
              state_reg       <= PRESENT;
            end
          end
        end
        PRESENT: begin
          if (!stall) begin
            instr_valid_reg <= 1'b0;
            instr_reg       <= NOP_INSTR;
            if (is_halt(instr_reg)) begin
              halted_reg <= 1'b1;
              state_reg  <= HALTED;
            end else begin
              mem_rd_reg <= 1'b1;
              state_reg  <= FETCH;
            end
          end
        end
        default: begin
          // HALTED: parked until reset or redirect.
          mem_rd_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr       = pc;
  assign mem_rd         = mem_rd_reg;
  assign instr          = instr_reg;
  assign next_PC_normal = next_pc_reg;
  assign instr_valid    = instr_valid_reg;
  assign halted         = halted_reg;
  assign err            = err_reg;

endmodule

// File: tb/tb_fetch_instruction.sv
// Bench for fetch_instruction: a behavioural instruction memory pushes the
// presentation it expects whenever it returns a word, a monitor pops and
// compares on each new presentation, and scenario tasks check cycle timing.
module tb_fetch_instruction;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_PC = 16'h0000;
  logic        stall = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_stall = 1'b0;
  logic        mem_done = 1'b0;
  logic [15:0] mem_data_in = 16'h0000;
  logic [15:0] instr;
  logic [15:0] next_PC_normal;
  logic        instr_valid;
  logic        halted;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model knobs and state
  int          mem_lat = 1;
  int          stall_budget = 0;
  int          accept_cnt = 0;
  bit          drop_next = 1'b0;
  bit          m_pend = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_addr = 16'h0000;
  logic [15:0] mem_img [int];

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] npc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  exp_t push_e;
  logic prev_valid = 1'b0;

  fetch_instruction dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_PC    (redirect_PC),
    .stall          (stall),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_stall      (mem_stall),
    .mem_done       (mem_done),
    .mem_data_in    (mem_data_in),
    .instr          (instr),
    .next_PC_normal (next_PC_normal),
    .instr_valid    (instr_valid),
    .halted         (halted),
    .err            (err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem_img.exists(int'(a))) return mem_img[int'(a)];
    return a ^ 16'hA000;
  endfunction

  // Instruction memory: drives mem_stall/mem_done on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (rst) begin
        m_pend    = 1'b0;
        mem_stall = 1'b0;
      end else begin
        if (m_pend) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_pend      = 1'b0;
            mem_done    = 1'b1;
            mem_data_in = mem_word(m_addr);
            if (drop_next) begin
              drop_next = 1'b0;
            end else begin
              push_e.instr = mem_data_in;
              push_e.npc   = m_addr + 16'd2;
              exp_q.push_back(push_e);
            end
          end
        end
        if (mem_rd && stall_budget > 0) begin
          mem_stall = 1'b1;
          stall_budget--;
        end else begin
          mem_stall = 1'b0;
          if (mem_rd) begin
            m_pend = 1'b1;
            m_cnt  = mem_lat;
            m_addr = mem_addr;
            accept_cnt++;
          end
        end
      end
    end
  end

  // Scoreboard monitor: each fresh presentation must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (instr_valid && !prev_valid) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: presented instr=%h npc=%h, required no presentation", instr, next_PC_normal);
          end else begin
            mon_e = exp_q.pop_front();
            if (instr !== mon_e.instr || next_PC_normal !== mon_e.npc) begin
              n_err++;
              $display("FAIL sb_present: got instr=%h npc=%h, required instr=%h npc=%h", instr, next_PC_normal, mon_e.instr, mon_e.npc);
            end else begin
              $display("present instr=%h npc=%h ok", instr, next_PC_normal);
            end
          end
        end
        prev_valid = instr_valid;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (instr_valid !== 1'b1 && k < 20) begin
      cyc(1);
      k++;
    end
    n_cmp++;
    if (instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_timeout: instr_valid=%b after %0d cycles, required 1", tag, instr_valid, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    n_cmp++;
    if (instr !== 16'h0800 || next_PC_normal !== 16'h0000 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_instr: got instr=%h npc=%h valid=%b, required 0800 0000 0", instr, next_PC_normal, instr_valid);
    end
    n_cmp++;
    if (halted !== 1'b0 || err !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_ctrl: got halted=%b err=%b mem_rd=%b addr=%h, required 0 0 0 0000", halted, err, mem_rd, mem_addr);
    end
  endtask

  task automatic test_first_fetch();
    mem_img[16'h0000] = 16'hC005;
    mem_lat = 1;
    rst = 1'b0;
    cyc(1);
    n_cmp++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
      n_err++;
      $display("FAIL first_req: got mem_rd=%b addr=%h, required 1 0000", mem_rd, mem_addr);
    end
    cyc(1);
    n_cmp++;
    if (mem_rd !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL first_wait: got mem_rd=%b valid=%b, required 0 0", mem_rd, instr_valid);
    end
    stall_budget = 2;
    cyc(1);
    n_cmp++;
    if (instr !== 16'hC005 || next_PC_normal !== 16'h0002 || instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL first_present: got instr=%h npc=%h valid=%b, required C005 0002 1", instr, next_PC_normal, instr_valid);
    end
    cyc(1);
  endtask

  task automatic test_mem_stall();
    int acc0;
    acc0 = accept_cnt;
    mem_img[16'h0002] = 16'h4123;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc(1);
      n_cmp++;
      if (mem_rd !== 1'b1 || mem_addr !== 16'h0002 || instr_valid !== 1'b0) begin
        n_err++;
        $display("FAIL memstall_hold%0d: got mem_rd=%b addr=%h valid=%b, required 1 0002 0", i, mem_rd, mem_addr, instr_valid);
      end
    end
    cyc(1);
    n_cmp++;
    if (mem_rd !== 1'b0) begin
      n_err++;
      $display("FAIL memstall_wait: got mem_rd=%b, required 0", mem_rd);
    end
    n_cmp++;
    if (accept_cnt - acc0 !== 1) begin
      n_err++;
      $display("FAIL memstall_accepts: got %0d accepted requests, required 1", accept_cnt - acc0);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      n_cmp++;
      if (instr !== 16'h4123 || next_PC_normal !== 16'h0004 || instr_valid !== 1'b1 || mem_rd !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold%0d: got instr=%h npc=%h valid=%b mem_rd=%b, required 4123 0004 1 0", i, instr, next_PC_normal, instr_valid, mem_rd);
      end
    end
    mem_lat = 3;
    mem_img[16'h0004] = 16'hDEAD;
    stall = 1'b0;
    cyc(1);
    n_cmp++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0004 || instr_valid !== 1'b0 || instr !== 16'h0800) begin
      n_err++;
      $display("FAIL stall_resume: got mem_rd=%b addr=%h valid=%b instr=%h, required 1 0004 0 0800", mem_rd, mem_addr, instr_valid, instr);
    end
  endtask

  task automatic test_redirect_squash();
    cyc(1);
    redirect    = 1'b1;
    redirect_PC = 16'h0040;
    drop_next   = 1'b1;
    cyc(1);
    redirect = 1'b0;
    mem_lat  = 1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) cyc(1);
      n_cmp++;
      if (instr_valid !== 1'b0 || mem_rd !== 1'b0) begin
        n_err++;
        $display("FAIL squash_wait%0d: got valid=%b mem_rd=%b, required 0 0", i, instr_valid, mem_rd);
      end
    end
    cyc(1);
    n_cmp++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0040 || instr_valid !== 1'b0 || instr !== 16'h0800) begin
      n_err++;
      $display("FAIL squash_refetch: got mem_rd=%b addr=%h valid=%b instr=%h, required 1 0040 0 0800", mem_rd, mem_addr, instr_valid, instr);
    end
    wait_valid("squash");
    n_cmp++;
    if (instr !== 16'hA040 || next_PC_normal !== 16'h0042) begin
      n_err++;
      $display("FAIL squash_target: got instr=%h npc=%h, required A040 0042", instr, next_PC_normal);
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    mem_img[16'h0010] = 16'h0000;
    redirect    = 1'b1;
    redirect_PC = 16'h0010;
    cyc(1);
    redirect = 1'b0;
    n_cmp++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0010 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL halt_req: got mem_rd=%b addr=%h valid=%b, required 1 0010 0", mem_rd, mem_addr, instr_valid);
    end
    wait_valid("halt");
    n_cmp++;
    if (instr !== 16'h0000 || next_PC_normal !== 16'h0012) begin
      n_err++;
      $display("FAIL halt_present: got instr=%h npc=%h, required 0000 0012", instr, next_PC_normal);
    end
    cyc(1);
    n_cmp++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || instr !== 16'h0800) begin
      n_err++;
      $display("FAIL halt_state: got halted=%b valid=%b instr=%h, required 1 0 0800", halted, instr_valid, instr);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (mem_rd !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL halt_idle: got %0d active cycles in 20, required 0", bad);
    end
    redirect    = 1'b1;
    redirect_PC = 16'h0020;
    cyc(1);
    redirect = 1'b0;
    n_cmp++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0020 || halted !== 1'b0) begin
      n_err++;
      $display("FAIL halt_restart: got mem_rd=%b addr=%h halted=%b, required 1 0020 0", mem_rd, mem_addr, halted);
    end
    wait_valid("restart");
    n_cmp++;
    if (instr !== 16'hA020 || next_PC_normal !== 16'h0022) begin
      n_err++;
      $display("FAIL restart_present: got instr=%h npc=%h, required A020 0022", instr, next_PC_normal);
    end
  endtask

  task automatic test_odd_err();
    int bad = 0;
    redirect    = 1'b1;
    redirect_PC = 16'h0031;
    cyc(1);
    redirect = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || halted !== 1'b1 || instr_valid !== 1'b0 || mem_rd !== 1'b0) begin
      n_err++;
      $display("FAIL odd_err: got err=%b halted=%b valid=%b mem_rd=%b, required 1 1 0 0", err, halted, instr_valid, mem_rd);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (mem_rd !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL odd_idle: got %0d request cycles, required 0", bad);
    end
    mem_lat     = 6;
    redirect    = 1'b1;
    redirect_PC = 16'h0050;
    cyc(1);
    redirect = 1'b0;
    n_cmp++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0050 || halted !== 1'b0 || err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky: got mem_rd=%b addr=%h halted=%b err=%b, required 1 0050 0 1", mem_rd, mem_addr, halted, err);
    end
    cyc(1);
    n_cmp++;
    if (mem_rd !== 1'b0) begin
      n_err++;
      $display("FAIL err_inwait: got mem_rd=%b, required 0", mem_rd);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (err !== 1'b0 || halted !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got err=%b halted=%b mem_rd=%b addr=%h valid=%b, required 0 0 0 0000 0", err, halted, mem_rd, mem_addr, instr_valid);
    end
    mem_lat = 1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    n_cmp++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_refetch: got mem_rd=%b addr=%h, required 1 0000", mem_rd, mem_addr);
    end
    wait_valid("refetch");
    n_cmp++;
    if (instr !== 16'hC005 || next_PC_normal !== 16'h0002) begin
      n_err++;
      $display("FAIL refetch_present: got instr=%h npc=%h, required C005 0002", instr, next_PC_normal);
    end
    cyc(1);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d unconsumed expectations, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_mem_stall();
    test_stall();
    test_redirect_squash();
    test_halt();
    test_odd_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
